// File: rtl/win_pkg.sv
// win_pkg: shared state type and sum-width helper for the sliding window averager
package win_pkg;
  typedef enum logic {FILL, RUN} state_t;
  function automatic int SUMW(input int nx, input int depth);
    return nx + $clog2(depth);
  endfunction
endpackage

// File: rtl/sample_ring.sv
// sample_ring: circular sample store; RDATA is the oldest entry, the one the next write replaces
module sample_ring #(
  parameter int NX = 8,
  parameter int DEPTH = 4
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          CLR,
  input  logic          WE,
  input  logic [NX-1:0] WDATA,
  output logic [NX-1:0] RDATA
);
  localparam int LW = $clog2(DEPTH);
  logic [NX-1:0] mem [DEPTH];
  logic [LW-1:0] wp;
  assign RDATA = mem[wp];
  always_ff @(posedge CLK) begin
    if (RST || CLR) begin
      mem <= '{default: '0};
      wp  <= '0;
    end else if (WE) begin
      mem[wp] <= WDATA;
      wp      <= wp + 1'b1;
    end
  end
endmodule

// File: rtl/xout_window_avg.sv
// xout_window_avg: running sum and floor average over the last DEPTH accepted XOUT samples
import win_pkg::*;
module xout_window_avg #(
  parameter int NX = 8,
  parameter int DEPTH = 4
) (
  input  logic                         CLK,
  input  logic                         RST,
  input  logic                         CLR,
  input  logic [NX-1:0]                XIN,
  input  logic                         XIN_VALID,
  output logic                         XIN_READY,
  output logic [SUMW(NX, DEPTH)-1:0]   SUM,
  output logic [NX-1:0]                AVG,
  output logic                         OUT_VALID,
  input  logic                         OUT_READY
);
  localparam int LW = $clog2(DEPTH);
  localparam int SW = SUMW(NX, DEPTH);
  localparam logic [LW:0] DMAX = (LW + 1)'(DEPTH);
  state_t        state;
  logic [LW:0]   cnt;
  logic [SW-1:0] acc_sum, sum_n;
  logic [NX-1:0] oldest;
  logic          acc, full_n;
  assign XIN_READY = !CLR && (!OUT_VALID || OUT_READY);
  assign acc       = XIN_VALID && XIN_READY;
  // oldest is already part of acc_sum, so this never underflows
  assign sum_n     = acc_sum + SW'(XIN) - SW'(oldest);
  assign full_n    = (state == RUN) || (cnt == DMAX - 1'b1);
  sample_ring #(.NX(NX), .DEPTH(DEPTH)) u_ring (
    .CLK(CLK), .RST(RST), .CLR(CLR), .WE(acc), .WDATA(XIN), .RDATA(oldest)
  );
  always_ff @(posedge CLK) begin
    if (RST) begin
      state     <= FILL;
      cnt       <= '0;
      acc_sum   <= '0;
      SUM       <= '0;
      AVG       <= '0;
      OUT_VALID <= 1'b0;
    end else if (CLR) begin
      state     <= FILL;
      cnt       <= '0;
      acc_sum   <= '0;
      OUT_VALID <= 1'b0;
    end else begin
      if (acc) begin
        acc_sum <= sum_n;
        cnt     <= (cnt == DMAX) ? cnt : cnt + 1'b1;
        state   <= full_n ? RUN : FILL;
      end
      if (acc && full_n) begin
        SUM       <= sum_n;
        AVG       <= sum_n[SW-1:LW];
        OUT_VALID <= 1'b1;
      end else if (OUT_VALID && OUT_READY) begin
        OUT_VALID <= 1'b0;
      end
    end
  end
endmodule

// File: doc/xout_window_avg.md
Name: xout_window_avg

Overview:
- Downstream consumer of the 8-bit arithmetic stage output XOUT (A - 3*B - 21, unsigned, wrapping).
- Takes one sample per accepted handshake, keeps the last DEPTH samples in a circular buffer, and emits the running window sum and average.
- Uses a valid/ready handshake on both sides so it can sit between the combinational arithmetic stage and a back-pressuring sink.

Parameters:
- NX, 8, sample width in bits; matches the XOUT width.
- DEPTH, 4, window length in samples; must be a power of 2 and ≥2.
- LW, $clog2(DEPTH), derived (localparam), window-index width.

Ports:
- CLK  input  1  clock; all state changes on the rising edge.
- RST  input  1  synchronous, active-high reset.
- CLR  input  1  synchronous window clear; returns the block to FILL.
- XIN  input  NX  sample, unsigned; driven from XOUT.
- XIN_VALID  input  1  XIN holds a valid sample.
- XIN_READY  output  1  block can accept a sample this cycle.
- SUM  output  NX+LW  sum of the last DEPTH samples, unsigned, never overflows.
- AVG  output  NX  SUM >> LW (floor).
- OUT_VALID  output  1  SUM/AVG valid.
- OUT_READY  input  1  sink accepts SUM/AVG.

Behaviour:
- Reset (RST=1 at an edge): the following all become 0: buffer entries, write pointer wp, fill count cnt, sum register, OUT_VALID, SUM, AVG. State becomes FILL. RST overrides CLR and all handshakes, and may be asserted mid-operation; in-flight output is discarded.
- Handshakes:
  - XIN_READY = !CLR && (!OUT_VALID || OUT_READY). It is combinational and has no dependency on XIN_VALID.
  - Accept = XIN_VALID && XIN_READY. Out-transfer = OUT_VALID && OUT_READY.
- On accept:
  - sum_n = sum + XIN - buf[wp], computed at NX+LW bits.
  - buf[wp] <= XIN.
  - wp <= wp+1, wrapping modulo DEPTH.
  - If cnt < DEPTH, cnt <= cnt+1.
- State machine:
  - FILL: fewer than DEPTH samples held. An accept with cnt == DEPTH-1 moves to RUN.
  - RUN: the window is full and stays in RUN until CLR or RST.
- Output register:
  - An accept that leaves the window full (the entering-RUN accept, or any accept while in RUN) loads SUM <= sum_n and AVG <= sum_n[NX+LW-1:LW], and sets OUT_VALID=1 on the next cycle. Accept-to-output latency is 1 cycle.
  - Accepts in FILL (other than the transition accept) produce no output.
  - On an out-transfer with no new output load, OUT_VALID <= 0.
  - Out-transfer and a new load in the same cycle: OUT_VALID stays 1 and SUM/AVG take the new values. Sustained throughput is 1 sample per cycle when OUT_READY=1.
  - While OUT_VALID && !OUT_READY: SUM/AVG are held stable, XIN_READY=0, and no state changes.
- CLR=1:
  - cnt, wp, sum and all buffer entries are cleared; state goes to FILL; OUT_VALID <= 0.
  - XIN_READY=0 that cycle, so a sample presented with CLR is not accepted; the upstream holds it.
- Arithmetic: all values are unsigned. The subtraction cannot underflow because buf[wp] is already included in sum. SUM max = DEPTH*(2^NX-1), e.g. 1020 at the defaults, which fits in NX+LW bits.

Decomposition:
- Shared package win_pkg:
  - State enum typedef {FILL, RUN}.
  - Function SUMW(NX, DEPTH) = NX + $clog2(DEPTH).
- One sub-module, sample_ring:
  - Contents: DEPTH x NX register array with wp, synchronous write, and an asynchronous read of buf[wp].
  - Inputs: CLK, RST, CLR, WE, WDATA.
  - Output: RDATA (the oldest sample).
- The top level holds the FSM, cnt, the sum register and the output register.

Test Plan:
- Fill, defaults, OUT_READY=1: XIN 10, 20, 30, 40 on consecutive cycles → OUT_VALID first rises the cycle after 40 is accepted, with SUM=100 and AVG=25. No OUT_VALID during the first three samples.
- Slide: continue with 50, 60 → SUM=140/AVG=35, then SUM=180/AVG=45; one output per cycle.
- Backpressure: hold OUT_READY=0 for 3 cycles with SUM=140 → SUM/AVG stable, XIN_READY=0, and XIN=60 held by the upstream is not consumed. Release → 60 accepted, next output SUM=180.
- Width/saturation bound: four samples of 255 → SUM=1020 with no wrap, AVG=255. Then feed 0 → SUM=765, AVG=191.
- CLR mid-run with XIN_VALID=1 and XIN=7 → sample not accepted, OUT_VALID=0 next cycle. Then 1, 2, 3, 4 → SUM=10, AVG=2.
- Reset mid-operation: RST for 1 cycle while OUT_VALID=1 → next cycle OUT_VALID=0, SUM=0, AVG=0. Refill with 8 ×4 → SUM=32, confirming the buffer was zeroed.
